bvurem_ugt_checker: RTL and testbench
=====================================

Name: bvurem_ugt_checker

Overview:
- Sequential checker for the Skolem witnesses of the bvugt/bvurem invertibility condition.
- Takes a candidate witness x and operands s and t, computes r = x urem s with a bit-serial restoring divider, and reports whether r >ugt t.
- Sits downstream of the combinational Skolem-function blocks and independently validates each produced witness bit-vector.
- Division follows SMT-LIB semantics: x urem 0 = x.

Parameters:
- W, 4, bit width of x, s, t and all result vectors (W >= 2).

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand set present
- in_ready  output  1  checker can accept operands
- x  input  W  candidate witness (dividend)
- s  input  W  divisor
- t  input  W  comparison bound
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- rem  output  W  x urem s
- quo  output  W  x udiv s (all-ones when s == 0)
- holds  output  1  1 iff rem >ugt t
- div_zero  output  1  s was zero for this result

Behaviour:
- Reset: asynchronous on rst_n low. State=IDLE, in_ready=0 during reset then 1 in IDLE, out_valid=0, rem=0, quo=0, holds=0, div_zero=0, internal registers 0.
- States are IDLE, DIV, RESP.
- IDLE:
  - in_ready=1.
  - A transfer occurs when in_valid && in_ready at a rising edge. The block then latches x, s and t.
  - If s==0: go to RESP with rem=x, quo={W{1}}, div_zero=1.
  - Otherwise: clear the W+1-bit partial remainder, load the shift register with x, set counter=W-1, and go to DIV.
- DIV:
  - in_ready=0. Exactly W cycles, one quotient bit per cycle, MSB first.
  - Each cycle: pr = {pr[W-1:0], xs[W-1]}; xs <<= 1.
  - If pr >= {1'b0,s}: pr -= s and shift 1 into quo; otherwise shift 0.
  - All arithmetic is unsigned at W+1 bits, and pr never exceeds 2*s-1.
  - When counter reaches 0, go to RESP. rem=pr[W-1:0], holds=(rem > t) is registered on the same edge, and div_zero=0.
- RESP:
  - out_valid=1, in_ready=0.
  - rem, quo, holds and div_zero are held stable while out_valid && !out_ready (no change under backpressure).
  - On out_valid && out_ready: go to IDLE, out_valid=0. Result outputs keep their last value.
- Latency from accept edge to out_valid high: W+1 cycles for s!=0, 1 cycle for s==0.
- Throughput: one operand set per W+2 cycles minimum. There is no overlap, and in_ready is low from accept until the result handshake completes.
- x < s (s!=0): rem=x, quo=0.
- t = all-ones: holds=0 always, because no r is ugt max.
- in_valid asserted during DIV/RESP is ignored, and operands are not sampled. The producer must hold them until in_ready.
- Reset asserted mid-DIV or mid-RESP: immediate return to reset values. The pending result is discarded and out_valid never pulses.
- Inputs x, s and t may change freely after the accept edge, since only the latched copies are used.
- All outputs are registered; there is no combinational input-to-output path except none.

Test Plan:
- W=4, x=13, s=4, t=0 accepted at edge 0 with out_ready=1 -> out_valid high after 5 cycles. rem=1, quo=3, holds=1, div_zero=0. in_ready returns the cycle after the handshake.
- W=4, x=9, s=0, t=8 -> out_valid after 1 cycle. rem=9, quo=15, div_zero=1, holds=1. Repeat with t=9 -> holds=0.
- W=4, x=3, s=7, t=3 -> rem=3, quo=0, holds=0. Also x=15, s=15, t=0 -> rem=0, quo=1, holds=0.
- Backpressure: out_ready=0 for 6 cycles after out_valid -> rem, quo and holds are constant, in_ready stays 0, and an in_valid pulse is ignored. Then out_ready=1 -> single handshake and IDLE.
- Reset mid-op: rst_n low at DIV cycle 2 -> out_valid=0 and in_ready=0 immediately, with all outputs at 0. After release, a new op x=10, s=3, t=0 yields rem=1, quo=3, holds=1.
- Exhaustive W=4 sweep of all (x,s,t) back-to-back with random out_ready stalls -> every result matches the reference model (x urem s, x udiv s, >ugt t, SMT-LIB zero rules). Zero lost or duplicated transfers.

Source files
------------

// File: rtl/bvurem_ugt_checker.sv
`default_nettype none
// ============================================================================
//  bvurem_ugt_checker : bit-serial restoring x urem s, then flags rem >u t
//  Rev 1.0
// ============================================================================
module bvurem_ugt_checker #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] s_i,
    input  logic [W-1:0] t_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quo_o,
    output logic         holds_o,
    output logic         div_zero_o
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         state_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic [W-1:0]   s_q;
    logic [W-1:0]   t_q;
    logic [W-1:0]   xs_q;
    logic [W-1:0]   pr_q;
    logic [W-1:0]   qacc_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   rem_q;
    logic [W-1:0]   quo_q;
    logic           holds_q;
    logic           dz_q;

    logic [W:0]     pr_shift;
    logic           pr_ge;
    logic [W-1:0]   pr_d;
    logic [W-1:0]   qacc_d;

    // After each restore step the remainder is below s, so W bits hold it;
    // only the shifted trial value needs the extra bit.
    always_comb begin
        pr_shift = {pr_q, xs_q[W-1]};
        pr_ge    = (pr_shift >= {1'b0, s_q});
        pr_d     = pr_ge ? W'(pr_shift - {1'b0, s_q}) : pr_shift[W-1:0];
        qacc_d   = {qacc_q[W-2:0], pr_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            t_q         <= '0;
            xs_q        <= '0;
            pr_q        <= '0;
            qacc_q      <= '0;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            holds_q     <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    if (in_valid_i && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        s_q        <= s_i;
                        t_q        <= t_i;
                        xs_q       <= x_i;
                        if (s_i == '0) begin
                            rem_q       <= x_i;
                            quo_q       <= '1;
                            holds_q     <= (x_i > t_i);
                            dz_q        <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else begin
                            pr_q    <= '0;
                            qacc_q  <= '0;
                            cnt_q   <= CW'(W - 1);
                            state_q <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    pr_q   <= pr_d;
                    xs_q   <= xs_q << 1;
                    qacc_q <= qacc_d;
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        rem_q       <= pr_d;
                        quo_q       <= qacc_d;
                        holds_q     <= (pr_d > t_q);
                        dz_q        <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign rem_o       = rem_q;
    assign quo_o       = quo_q;
    assign holds_o     = holds_q;
    assign div_zero_o  = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_bvurem_ugt_checker.sv
`default_nettype none
// ============================================================================
//  tb_bvurem_ugt_checker : directed vectors, cycle model, exhaustive W=4 sweep
//  Rev 1.0
// ============================================================================
module tb_bvurem_ugt_checker;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] x = '0;
    logic [W-1:0] s = '0;
    logic [W-1:0] t = '0;
    logic         in_ready_o;
    logic         out_valid_o;
    logic [W-1:0] rem_o;
    logic [W-1:0] quo_o;
    logic         holds_o;
    logic         div_zero_o;

    bvurem_ugt_checker #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_o),
        .x_i         (x),
        .s_i         (s),
        .t_i         (t),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready),
        .rem_o       (rem_o),
        .quo_o       (quo_o),
        .holds_o     (holds_o),
        .div_zero_o  (div_zero_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_sent   = 0;
    int n_acc    = 0;
    int n_res    = 0;
    bit rnd_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding operation, result due a fixed
    // number of edges after acceptance, computed with plain arithmetic.
    bit           m_busy = 1'b0;
    bit           m_rdy  = 1'b0;
    int           m_cnt  = 0;
    int           m_lat  = 0;
    logic [W-1:0] m_rem, m_quo;
    logic         m_holds, m_dz;

    always @(negedge clk) begin
        bit exp_ov;
        if (!rst_n) begin
            chk("rst out_valid", out_valid_o, 0);
            chk("rst in_ready", in_ready_o, 0);
            chk("rst rem", rem_o, 0);
            chk("rst quo", quo_o, 0);
            chk("rst holds", holds_o, 0);
            chk("rst div_zero", div_zero_o, 0);
            m_busy = 1'b0;
            m_rdy  = 1'b0;
        end else begin
            exp_ov = m_busy && (m_cnt >= m_lat);
            chk("out_valid", out_valid_o, exp_ov);
            chk("in_ready", in_ready_o, m_rdy);
            if (exp_ov) begin
                chk("rem", rem_o, m_rem);
                chk("quo", quo_o, m_quo);
                chk("holds", holds_o, m_holds);
                chk("div_zero", div_zero_o, m_dz);
            end
            if (exp_ov && out_ready) begin
                m_busy = 1'b0;
                n_res++;
            end else if (!m_busy && m_rdy && in_valid) begin
                m_dz    = (s == 0);
                m_rem   = m_dz ? x : x % s;
                m_quo   = m_dz ? {W{1'b1}} : x / s;
                m_holds = (m_rem > t);
                m_lat   = m_dz ? 0 : W;
                m_cnt   = 0;
                m_busy  = 1'b1;
                n_acc++;
            end else if (m_busy) begin
                m_cnt++;
            end
            m_rdy = !m_busy;
        end
    end

    always @(posedge clk) begin
        if (rnd_mode) begin
            #2;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [W-1:0] xv, input logic [W-1:0] sv, input logic [W-1:0] tv);
        bit r;
        r = 1'b0;
        x = xv; s = sv; t = tv;
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            r = in_ready_o;
            @(posedge clk);
            #2;
            if (r) break;
        end
        chk("accept timeout", r, 1);
        in_valid = 1'b0;
        x = W'($urandom); s = W'($urandom); t = W'($urandom);
        n_sent++;
    endtask

    task automatic wait_ov(output int lat);
        lat = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            lat++;
            if (out_valid_o) break;
        end
        chk("out_valid timeout", out_valid_o, 1);
    endtask

    task automatic expect_res(input int er, input int eq, input int eh, input int ed, input int el);
        int l;
        wait_ov(l);
        chk("latency", l, el);
        chk("lit rem", rem_o, er);
        chk("lit quo", quo_o, eq);
        chk("lit holds", holds_o, eh);
        chk("lit div_zero", div_zero_o, ed);
        @(posedge clk);
        #2;
    endtask

    initial begin
        int l, acc0, res0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #2;

        send(13, 4, 0);
        expect_res(1, 3, 1, 0, 5);
        @(negedge clk);
        chk("in_ready after handshake", in_ready_o, 1);
        @(posedge clk); #2;

        send(9, 0, 8);   expect_res(9, 15, 1, 1, 1);
        send(9, 0, 9);   expect_res(9, 15, 0, 1, 1);
        send(14, 0, 15); expect_res(14, 15, 0, 1, 1);
        send(3, 7, 3);   expect_res(3, 0, 0, 0, 5);
        send(15, 15, 0); expect_res(0, 1, 0, 0, 5);
        send(12, 5, 15); expect_res(2, 2, 0, 0, 5);

        // Backpressure with an in_valid pulse that must be ignored
        out_ready = 1'b0;
        send(11, 3, 1);
        wait_ov(l);
        chk("bp latency", l, 5);
        acc0 = n_acc;
        @(posedge clk); #2;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i == 2);
            x = 1; s = 1; t = 0;
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp rem", rem_o, 2);
        chk("bp quo", quo_o, 3);
        chk("bp holds", holds_o, 1);
        chk("bp in_ready", in_ready_o, 0);
        chk("bp out_valid", out_valid_o, 1);
        chk("bp no accept", n_acc, acc0);
        res0 = n_res;
        @(posedge clk); #2 out_ready = 1'b1;
        @(posedge clk); #2 out_ready = 1'b0;
        @(negedge clk);
        chk("bp single handshake", n_res, res0 + 1);
        chk("bp out_valid drop", out_valid_o, 0);
        chk("bp idle ready", in_ready_o, 1);
        @(posedge clk); #2 out_ready = 1'b1;

        // Reset during the divide
        res0 = n_res;
        send(13, 5, 0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", out_valid_o, 0);
        chk("midrst in_ready", in_ready_o, 0);
        chk("midrst rem", rem_o, 0);
        chk("midrst quo", quo_o, 0);
        chk("midrst holds", holds_o, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;
        chk("midrst no result", n_res, res0);
        send(10, 3, 0);
        expect_res(1, 3, 1, 0, 5);

        // Exhaustive sweep under random consumer stalls
        n_sent = 0; n_acc = 0; n_res = 0;
        rnd_mode = 1'b1;
        for (int xi = 0; xi < 16; xi++)
            for (int si = 0; si < 16; si++)
                for (int ti = 0; ti < 16; ti++)
                    send(W'(xi), W'(si), W'(ti));
        for (int n = 0; n < 100 && m_busy; n++) @(posedge clk);
        chk("drain", m_busy, 0);
        rnd_mode = 1'b0;
        chk("accepted count", n_acc, n_sent);
        chk("result count", n_res, n_sent);
        chk("sweep size", n_sent, 4096);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
